servo_pwm_array: RTL and testbench



---
 rtl/servo_pkg.sv | 22 ++
 rtl/servo_pwm_array_if.sv | 16 +
 rtl/servo_pwm_array_ch.sv | 59 +++++
 rtl/servo_pwm_array.sv | 103 ++++++++++
 tb/tb_servo_pwm_array.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared register map and bit-field helpers for the servo PWM array.
// Offsets are byte addresses within the decoded PADDR[11:0] window.
package servo_pkg;
    localparam int          MAX_CH      = 8;
    localparam logic [11:0] CH_STRIDE   = 12'h010;
    localparam logic [11:0] OFF_TARGET  = 12'h000;
    localparam logic [11:0] OFF_CURRENT = 12'h004;
    localparam logic [11:0] OFF_STEP    = 12'h008;
    localparam logic [11:0] ADDR_CTRL   = 12'h100;
    localparam logic [11:0] ADDR_PERIOD = 12'h104;
    localparam logic [11:0] ADDR_STATUS = 12'h108;

    // Packs a per-channel bit vector into a 32-bit read word, zeroing bits >= n.
    function automatic logic [31:0] ch_field(input logic [MAX_CH-1:0] bits, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n) r[i] = bits[i];
        end
        return r;
    endfunction
endpackage

// File: rtl/servo_pwm_array_if.sv
// APB3 signal bundle between the fabric master and the servo PWM array.
interface servo_pwm_array_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/servo_pwm_array_ch.sv
// One servo channel: TARGET/STEP/CURRENT registers, clamped slew update at
// the frame wrap, and the registered output compare.
module servo_ch
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PW_NEUTRAL = 150000,
    parameter int unsigned PW_MIN     = 100000,
    parameter int unsigned PW_MAX     = 200000
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_target,
    input  logic             wr_step,
    input  logic [CNT_W-1:0] wdata,
    input  logic             wrap,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] current,
    output logic             busy,
    output logic             pwm
);
    logic [CNT_W-1:0] target_reg, step_reg, current_reg, current_next;
    logic [CNT_W-1:0] t_clamp, diff;
    logic             pwm_reg;

    always_comb begin
        t_clamp = target_reg;
        if (target_reg < CNT_W'(PW_MIN))      t_clamp = CNT_W'(PW_MIN);
        else if (target_reg > CNT_W'(PW_MAX)) t_clamp = CNT_W'(PW_MAX);
        // Subtract the smaller from the larger so the distance never wraps.
        diff = (t_clamp >= current_reg) ? (t_clamp - current_reg) : (current_reg - t_clamp);
        if (step_reg == '0 || diff <= step_reg) current_next = t_clamp;
        else if (t_clamp > current_reg)         current_next = current_reg + step_reg;
        else                                    current_next = current_reg - step_reg;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            target_reg  <= CNT_W'(PW_NEUTRAL);
            step_reg    <= '0;
            current_reg <= CNT_W'(PW_NEUTRAL);
            pwm_reg     <= 1'b0;
        end else begin
            if (wr_target) target_reg <= wdata;
            if (wr_step)   step_reg   <= wdata;
            if (wrap)      current_reg <= current_next;
            pwm_reg <= en & (cnt < current_reg);
        end
    end

    assign target  = target_reg;
    assign step    = step_reg;
    assign current = current_reg;
    assign busy    = (current_reg != t_clamp);
    assign pwm     = pwm_reg;
endmodule

// File: rtl/servo_pwm_array.sv
// N-channel servo PWM generator on APB3: address decode, frame counter,
// double-buffered PERIOD and channel enables; per-channel logic in servo_ch.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned PERIOD_DEFAULT = 2000000,
    parameter int unsigned PW_NEUTRAL     = 150000,
    parameter int unsigned PW_MIN         = 100000,
    parameter int unsigned PW_MAX         = 200000
) (
    input  logic              PCLK,
    input  logic              PRESET,
    servo_pwm_array_if.slave  apb,
    output logic [NUM_CH-1:0] pwm_out
);
    logic [CNT_W-1:0]  cnt_reg, cnt_next, period_active_reg, period_shadow_reg;
    logic [NUM_CH-1:0] ctrl_reg, busy;
    logic              wrap, acc, mapped, ro, err_c, wr_ok, in_ch;
    logic [11:0]       addr, ch_off;
    logic [7:0]        ch_sel;
    logic [31:0]       rd_val;
    logic [CNT_W-1:0]  target [NUM_CH];
    logic [CNT_W-1:0]  step   [NUM_CH];
    logic [CNT_W-1:0]  current[NUM_CH];
    logic              unused_paddr_hi;

    assign unused_paddr_hi = ^apb.PADDR[31:12];
    assign addr   = apb.PADDR[11:0];
    assign acc    = apb.PSEL & apb.PENABLE;
    assign in_ch  = (addr < ADDR_CTRL);
    assign ch_sel = 8'(addr / CH_STRIDE);
    assign ch_off = addr % CH_STRIDE;

    always_comb begin
        mapped = 1'b0;
        ro     = 1'b0;
        rd_val = '0;
        if (in_ch) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(ch_sel) == i) begin
                    case (ch_off)
                        OFF_TARGET:  begin mapped = 1'b1; rd_val = 32'(target[i]); end
                        OFF_CURRENT: begin mapped = 1'b1; ro = 1'b1; rd_val = 32'(current[i]); end
                        OFF_STEP:    begin mapped = 1'b1; rd_val = 32'(step[i]); end
                        default: ;
                    endcase
                end
            end
        end else begin
            case (addr)
                ADDR_CTRL:   begin mapped = 1'b1; rd_val = ch_field(MAX_CH'(ctrl_reg), NUM_CH); end
                ADDR_PERIOD: begin mapped = 1'b1; rd_val = 32'(period_shadow_reg); end
                ADDR_STATUS: begin mapped = 1'b1; ro = 1'b1; rd_val = ch_field(MAX_CH'(busy), NUM_CH); end
                default: ;
            endcase
        end
    end

    assign err_c       = ~mapped | (apb.PWRITE & ro);
    assign wr_ok       = acc & apb.PWRITE & ~err_c;
    assign apb.PSLVERR = acc & err_c;
    assign apb.PRDATA  = (acc & ~apb.PWRITE) ? rd_val : 32'd0;
    assign apb.PREADY  = 1'b1;

    assign wrap     = (cnt_reg == period_active_reg - CNT_W'(1));
    assign cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_reg           <= '0;
            period_active_reg <= CNT_W'(PERIOD_DEFAULT);
            period_shadow_reg <= CNT_W'(PERIOD_DEFAULT);
            ctrl_reg          <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (wrap) period_active_reg <= period_shadow_reg;
            if (wr_ok && addr == ADDR_CTRL) ctrl_reg <= apb.PWDATA[NUM_CH-1:0];
            // A period below 2 cycles cannot hold a frame, so such writes are dropped.
            if (wr_ok && addr == ADDR_PERIOD && apb.PWDATA >= 32'd2)
                period_shadow_reg <= CNT_W'(apb.PWDATA);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr_target, wr_step;
            assign wr_target = wr_ok & in_ch & (ch_sel == 8'(gi)) & (ch_off == OFF_TARGET);
            assign wr_step   = wr_ok & in_ch & (ch_sel == 8'(gi)) & (ch_off == OFF_STEP);

            servo_ch #(
                .CNT_W(CNT_W), .PW_NEUTRAL(PW_NEUTRAL), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
            ) u_ch (
                .clk(PCLK), .srst(PRESET),
                .wr_target(wr_target), .wr_step(wr_step), .wdata(CNT_W'(apb.PWDATA)),
                .wrap(wrap), .en(ctrl_reg[gi]), .cnt(cnt_reg),
                .target(target[gi]), .step(step[gi]), .current(current[gi]),
                .busy(busy[gi]), .pwm(pwm_out[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array with a 100-cycle frame and 10..90 clamp.
module tb_servo_pwm_array;
    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] pwm_out;
    int         total = 0;
    int         bad   = 0;

    servo_pwm_array_if bus();

    servo_pwm_array #(
        .NUM_CH(2), .CNT_W(32), .PERIOD_DEFAULT(100),
        .PW_NEUTRAL(50), .PW_MIN(10), .PW_MAX(90)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus), .pwm_out(pwm_out)
    );

    always #5 PCLK = ~PCLK;

    // Pulse monitor: high-time and rise-to-rise period per channel.
    int         cyc = 0;
    int         rises[2] = '{0, 0};
    int         falls[2] = '{0, 0};
    int         hi[2] = '{0, 0};
    int         last_high[2] = '{0, 0};
    int         last_period[2] = '{0, 0};
    int         rise_t[2] = '{0, 0};
    logic [1:0] prev = '0;

    always @(negedge PCLK) begin
        cyc <= cyc + 1;
        for (int c = 0; c < 2; c++) begin
            if (pwm_out[c] === 1'b1 && prev[c] == 1'b0) begin
                last_period[c] <= cyc - rise_t[c];
                rise_t[c]      <= cyc;
                rises[c]       <= rises[c] + 1;
                hi[c]          <= 1;
            end else if (pwm_out[c] === 1'b1) begin
                hi[c] <= hi[c] + 1;
            end
            if (pwm_out[c] !== 1'b1 && prev[c] == 1'b1) begin
                last_high[c] <= hi[c];
                falls[c]     <= falls[c] + 1;
            end
            prev[c] <= (pwm_out[c] === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wdata;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1;
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        @(posedge PCLK);
        #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd; logic err;
        apb(1'b1, addr, data, rd, err);
        check($sformatf("wr %03h slverr", addr), {31'd0, err}, {31'd0, exp_err});
        $display("write addr=%03h data=%0d slverr=%0b", addr, data, err);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err);
        logic [31:0] data; logic err;
        apb(1'b0, addr, 32'd0, data, err);
        check($sformatf("rd %03h data", addr), data, exp);
        check($sformatf("rd %03h slverr", addr), {31'd0, err}, {31'd0, exp_err});
        $display("read  addr=%03h data=%0d slverr=%0b", addr, data, err);
    endtask

    task automatic wait_rise(input int c);
        int r0 = rises[c];
        int n  = 0;
        while (rises[c] == r0 && n < 300) begin @(posedge PCLK); n++; end
        if (rises[c] == r0) begin
            total++; bad++;
            $error("FAIL rise_timeout ch%0d: got none expected a rising edge", c);
        end
    endtask

    task automatic wait_fall(input int c);
        int f0 = falls[c];
        int n  = 0;
        while (falls[c] == f0 && n < 300) begin @(posedge PCLK); n++; end
        if (falls[c] == f0) begin
            total++; bad++;
            $error("FAIL fall_timeout ch%0d: got none expected a falling edge", c);
        end
    endtask

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        check("reset pwm_out", {30'd0, pwm_out}, 32'd0);
        check("reset prdata", bus.PRDATA, 32'd0);
        check("reset pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        check("pready", {31'd0, bus.PREADY}, 32'd1);
        PRESET = 1'b0;

        rd(32'h100, 32'd0, 1'b0);
        rd(32'h004, 32'd50, 1'b0);
        rd(32'h000, 32'd50, 1'b0);
        rd(32'h104, 32'd100, 1'b0);
        rd(32'h108, 32'd0, 1'b0);

        // Enable both channels, then retarget ch0 inside a full 50-cycle pulse.
        wr(32'h100, 32'd3, 1'b0);
        wait_fall(0);
        wait_rise(0);
        wr(32'h000, 32'd30, 1'b0);
        rd(32'h108, 32'd1, 1'b0);
        wait_fall(0);
        check("ch0 high old target", last_high[0], 50);
        wait_fall(0);
        check("ch0 high new target", last_high[0], 30);
        check("ch0 period 100", last_period[0], 100);
        rd(32'h108, 32'd0, 1'b0);

        // Slew ch1 from 50 to 90 in steps of 8.
        wr(32'h018, 32'd8, 1'b0);
        wr(32'h010, 32'd90, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            wait_rise(1);
            rd(32'h014, 32'(50 + 8 * k), 1'b0);
            rd(32'h108, (k < 5) ? 32'd2 : 32'd0, 1'b0);
        end
        wait_fall(1);
        check("ch1 high at 90", last_high[1], 90);

        // Clamping: raw TARGET reads back, effective width is clamped.
        wait_rise(0);
        wr(32'h000, 32'd5, 1'b0);
        rd(32'h000, 32'd5, 1'b0);
        wait_fall(0);
        check("ch0 high before clamp", last_high[0], 30);
        wait_fall(0);
        check("ch0 high clamp min", last_high[0], 10);
        wr(32'h000, 32'd200, 1'b0);
        rd(32'h000, 32'd200, 1'b0);
        wait_fall(0);
        check("ch0 high clamp max", last_high[0], 90);
        rd(32'h004, 32'd90, 1'b0);

        // PERIOD change takes effect at the next wrap; tiny periods are dropped.
        wait_rise(0);
        wr(32'h000, 32'd30, 1'b0);
        wr(32'h104, 32'd60, 1'b0);
        rd(32'h104, 32'd60, 1'b0);
        wait_rise(0);
        check("period before change", last_period[0], 100);
        wait_rise(0);
        check("period after change", last_period[0], 60);
        @(negedge PCLK);
        check("ch1 stays high when width>=period", {31'd0, pwm_out[1]}, 32'd1);
        wr(32'h104, 32'd1, 1'b0);
        rd(32'h104, 32'd60, 1'b0);
        wait_rise(0);
        check("period ignores 1", last_period[0], 60);

        // Error responses leave state untouched.
        rd(32'h10C, 32'd0, 1'b1);
        wr(32'h108, 32'hFF, 1'b1);
        rd(32'h108, 32'd0, 1'b0);
        wr(32'h004, 32'd77, 1'b1);
        rd(32'h004, 32'd30, 1'b0);
        wr(32'h00C, 32'd77, 1'b1);
        wr(32'h020, 32'd77, 1'b1);
        rd(32'h020, 32'd0, 1'b1);
        rd(32'h000, 32'd30, 1'b0);

        // Reset in the middle of a pulse.
        wait_rise(0);
        repeat (2) @(negedge PCLK);
        check("pwm high before reset", {30'd0, pwm_out}, 32'd3);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("pwm low after reset", {30'd0, pwm_out}, 32'd0);
        PRESET = 1'b0;
        rd(32'h100, 32'd0, 1'b0);
        rd(32'h000, 32'd50, 1'b0);
        rd(32'h004, 32'd50, 1'b0);
        rd(32'h014, 32'd50, 1'b0);
        rd(32'h018, 32'd0, 1'b0);
        rd(32'h104, 32'd100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
